tff_toggle_sequencer: RTL and testbench

Controller that sequences a single T flip-flop cell. It drives the cell's ENABLE and T inputs to produce a programmed number of output toggles, spaced by a programmed idle gap. Lab-level clients use it as a pulse-train and divider-style pattern source. It exposes BUSY and DONE status to a host FSM or testbench.

---
 rtl/tff_toggle_sequencer_pkg.sv | 20 ++
 rtl/tff_toggle_sequencer_cell.sv | 21 ++
 rtl/tff_toggle_sequencer.sv | 126 ++++++++++++
 tb/tb_tff_toggle_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_toggle_sequencer_pkg.sv
// Shared definitions for the T flip-flop toggle sequencer: FSM state
// encoding and default widths of the toggle-count and gap counters.
package tff_toggle_sequencer_pkg;

    // Default width of the toggle-count input and remaining-toggle counter.
    localparam int DEF_CNT_W = 8;

    // Default width of the gap input and gap counter.
    localparam int DEF_GAP_W = 4;

    // Controller states. The encoding is fixed so that the state can be
    // read from a waveform without needing a decoder.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TOGGLE = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : tff_toggle_sequencer_pkg

// File: rtl/tff_toggle_sequencer_cell.sv
// Single T flip-flop cell with enable and asynchronous active-low reset.
// The output flips on a rising clock edge when both enable and t are high.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic t,
    output logic y
);

    // Toggle storage: flip on an enabled edge, clear on reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y <= 1'b0;
        end else if (enable && t) begin
            y <= ~y;
        end
    end

endmodule : tff_cell

// File: rtl/tff_toggle_sequencer.sv
// Toggle sequencer: drives a T flip-flop cell to produce a programmed number
// of output toggles, separated by a programmed number of idle cycles.
// Reports progress with a registered BUSY level and a one-cycle DONE pulse.
//
// Timing for a START accepted at edge n with count N and gap G:
//   toggles land on edges n+1+k*(G+1), k = 0..N-1
//   BUSY is high from edge n until the last toggle edge
//   DONE is high for the single cycle following the last toggle edge
module tff_toggle_sequencer
    import tff_toggle_sequencer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int GAP_W = DEF_GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] ntog,
    input  logic [GAP_W-1:0] gap,
    output logic             y,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] rem;      // toggles still to perform, including the current one
    logic [GAP_W-1:0] gp;       // gap length latched at START acceptance
    logic [GAP_W-1:0] gcnt;     // idle cycles left in the current gap
    logic             cell_t;
    logic             cell_en;

    // The cell is armed only in TOGGLE. ABORT gates the enable in the same
    // cycle so a cancelled toggle never reaches the flip-flop.
    assign cell_t  = (state == ST_TOGGLE);
    assign cell_en = (state == ST_TOGGLE) && !abort;

    tff_cell u_cell (
        .clk    (clk),
        .rst    (rst),
        .enable (cell_en),
        .t      (cell_t),
        .y      (y)
    );

    // Controller FSM with counters, input latches and registered status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            rem   <= '0;
            gp    <= '0;
            gcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    // ABORT takes precedence over START while idle.
                    if (start && !abort) begin
                        if (ntog != '0) begin
                            rem   <= ntog;
                            gp    <= gap;
                            busy  <= 1'b1;
                            state <= ST_TOGGLE;
                        end else begin
                            // Zero-length sequence: report completion only.
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end
                    end
                end

                ST_TOGGLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        // The remaining count never wraps below zero.
                        if (rem != '0) begin
                            rem <= rem - CNT_W'(1);
                        end
                        if (rem == CNT_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else if (gp == '0) begin
                            state <= ST_TOGGLE;
                        end else begin
                            gcnt  <= gp;
                            state <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        if (gcnt != '0) begin
                            gcnt <= gcnt - GAP_W'(1);
                        end
                        // The last idle cycle hands straight back to TOGGLE.
                        if (gcnt <= GAP_W'(1)) begin
                            state <= ST_TOGGLE;
                        end
                    end
                end

                ST_DONE: begin
                    // One-cycle completion pulse; START is not queued here.
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : tff_toggle_sequencer

// File: tb/tb_tff_toggle_sequencer.sv
// Self-checking bench for tff_toggle_sequencer: a directed vector table,
// hand-written abort and asynchronous reset sequences, counter boundary runs
// and randomized traffic checked against a schedule-based reference model.
module tb_tff_toggle_sequencer;

    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] ntog = '0;
    logic [GAP_W-1:0] gap = '0;
    logic             y;
    logic             busy;
    logic             done;

    int checks   = 0;
    int failures = 0;

    tff_toggle_sequencer #(
        .CNT_W (CNT_W),
        .GAP_W (GAP_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .ntog  (ntog),
        .gap   (gap),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference model: a sequence accepted at edge s with count N and gap G
    // toggles on edges s+1+k*(G+1) for k < N, with DONE the cycle after the
    // last toggle. Tracked as elapsed edges since acceptance.
    int cyc;
    bit m_active;
    bit m_busy;
    bit m_done;
    bit m_y;
    int m_start;
    int m_n;
    int m_g;

    task automatic model_reset();
        m_active = 0;
        m_busy   = 0;
        m_done   = 0;
        m_y      = 0;
        m_start  = 0;
        m_n      = 0;
        m_g      = 0;
    endtask

    task automatic model_edge();
        int e;
        cyc++;
        if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            e = cyc - m_start;
            if (abort) begin
                m_active = 0;
                m_busy   = 0;
            end else if ((e - 1) % (m_g + 1) == 0) begin
                m_y = ~m_y;
                if ((e - 1) / (m_g + 1) == m_n - 1) begin
                    m_active = 0;
                    m_busy   = 0;
                    m_done   = 1;
                end
            end
        end else if (start && !abort) begin
            if (ntog == 0) begin
                m_done = 1;
            end else begin
                m_active = 1;
                m_busy   = 1;
                m_start  = cyc;
                m_n      = int'(ntog);
                m_g      = int'(gap);
            end
        end
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: y/busy/done got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: the model follows the edge, outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run_model(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check(name, {y, busy, done}, {m_y, m_busy, m_done});
            start = 1'b0;
        end
    endtask

    typedef struct {
        logic             st;
        logic             ab;
        logic [CNT_W-1:0] nt;
        logic [GAP_W-1:0] gp;
        logic [2:0]       exp;   // {y, busy, done} after the edge
    } vec_t;

    vec_t vecs[21];

    logic y_pre;

    initial begin
        cyc = 0;
        model_reset();

        // Directed table, starting from reset with y = 0.
        vecs[0]  = '{1'b1, 1'b0, 8'd3, 4'd2, 3'b010};   // accept N=3 G=2
        vecs[1]  = '{1'b0, 1'b0, 8'd9, 4'd0, 3'b110};   // toggle 1; new inputs ignored
        vecs[2]  = '{1'b0, 1'b0, 8'd9, 4'd0, 3'b110};
        vecs[3]  = '{1'b0, 1'b0, 8'd9, 4'd0, 3'b110};
        vecs[4]  = '{1'b0, 1'b0, 8'd0, 4'd0, 3'b010};   // toggle 2
        vecs[5]  = '{1'b0, 1'b0, 8'd0, 4'd0, 3'b010};
        vecs[6]  = '{1'b0, 1'b0, 8'd0, 4'd0, 3'b010};
        vecs[7]  = '{1'b0, 1'b0, 8'd0, 4'd0, 3'b101};   // toggle 3, DONE
        vecs[8]  = '{1'b0, 1'b0, 8'd0, 4'd0, 3'b100};
        vecs[9]  = '{1'b1, 1'b0, 8'd4, 4'd0, 3'b110};   // accept N=4 G=0
        vecs[10] = '{1'b0, 1'b0, 8'd4, 4'd0, 3'b010};
        vecs[11] = '{1'b1, 1'b0, 8'd7, 4'd0, 3'b110};   // mid-sequence START ignored
        vecs[12] = '{1'b0, 1'b0, 8'd4, 4'd0, 3'b010};
        vecs[13] = '{1'b0, 1'b0, 8'd4, 4'd0, 3'b101};   // 4th toggle, DONE
        vecs[14] = '{1'b1, 1'b0, 8'd2, 4'd0, 3'b100};   // START in DONE ignored
        vecs[15] = '{1'b0, 1'b0, 8'd2, 4'd0, 3'b100};
        vecs[16] = '{1'b1, 1'b0, 8'd0, 4'd3, 3'b101};   // zero-length sequence
        vecs[17] = '{1'b0, 1'b0, 8'd0, 4'd3, 3'b100};
        vecs[18] = '{1'b1, 1'b1, 8'd2, 4'd0, 3'b100};   // ABORT beats START in IDLE
        vecs[19] = '{1'b0, 1'b0, 8'd2, 4'd0, 3'b100};
        vecs[20] = '{1'b0, 1'b1, 8'd2, 4'd0, 3'b100};   // ABORT in IDLE harmless

        // Reset held across several edges.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", {y, busy, done}, 3'b000);
        rst = 1'b1;
        step();
        check("reset_release", {y, busy, done}, 3'b000);

        for (int i = 0; i < 21; i++) begin
            start = vecs[i].st;
            abort = vecs[i].ab;
            ntog  = vecs[i].nt;
            gap   = vecs[i].gp;
            step();
            check($sformatf("vec%0d", i), {y, busy, done}, vecs[i].exp);
        end
        abort = 1'b0;
        start = 1'b0;

        // ABORT during the second TOGGLE cycle of N=5 G=1.
        y_pre = m_y;
        start = 1'b1; ntog = 8'd5; gap = 4'd1;
        step();
        check("abort_accept", {y, busy, done}, {y_pre, 2'b10});
        start = 1'b0;
        step();
        check("abort_tog1", {y, busy, done}, {~y_pre, 2'b10});
        step();
        check("abort_gap", {y, busy, done}, {~y_pre, 2'b10});
        abort = 1'b1;
        step();
        check("abort_hit", {y, busy, done}, {~y_pre, 2'b00});
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_quiet", {y, busy, done}, {~y_pre, 2'b00});
        end
        start = 1'b1; ntog = 8'd1; gap = 4'd3;
        step();
        check("abort_restart", {y, busy, done}, {~y_pre, 2'b10});
        start = 1'b0;
        step();
        check("abort_restart_done", {y, busy, done}, {y_pre, 2'b01});
        step();
        check("abort_restart_idle", {y, busy, done}, {y_pre, 2'b00});

        // Asynchronous reset between edges while in GAP.
        start = 1'b1; ntog = 8'd3; gap = 4'd5;
        step();
        start = 1'b0;
        step();
        step();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("async_reset", {y, busy, done}, 3'b000);
        model_reset();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("async_reset_hold", {y, busy, done}, 3'b000);
        rst = 1'b1;
        start = 1'b1; ntog = 8'd1; gap = 4'd0;
        step();
        check("post_reset_accept", {y, busy, done}, 3'b010);
        start = 1'b0;
        step();
        check("post_reset_done", {y, busy, done}, 3'b101);
        step();
        check("post_reset_idle", {y, busy, done}, 3'b100);

        // Counter extremes: maximum toggle count, maximum gap.
        start = 1'b1; ntog = 8'd255; gap = 4'd0;
        run_model("max_ntog", 260);
        start = 1'b1; ntog = 8'd3; gap = 4'd15;
        run_model("max_gap", 52);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 4) == 0;
            abort = ($urandom % 40) == 0;
            ntog  = (($urandom % 10) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
            gap   = (($urandom % 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
            step();
            check("random", {y, busy, done}, {m_y, m_busy, m_done});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tff_toggle_sequencer
